// File: rtl/tap_bridge_pkg.sv
// Shared constants and FSM state encoding for the JTAG USER4 bridge.
package tap_bridge_pkg;

   localparam int BYTE_WIDTH    = 8;
   localparam int BIT_CNT_WIDTH = 6;

   typedef logic [1:0] state_t;

   localparam state_t IDLE     = 2'd0;
   localparam state_t CAPTURED = 2'd1;
   localparam state_t SHIFTING = 2'd2;

endpackage

// File: rtl/tap_result_shifter.sv
// Result readback register: parallel load on capture, LSB-first shift toward tdo.
module tap_result_shifter #(
   parameter int RESULT_WIDTH = 32
) (
   input  logic                    tck,
   input  logic                    test_logic_reset,
   input  logic                    capture_load,
   input  logic                    shift_en,
   input  logic [RESULT_WIDTH-1:0] load_value,
   output logic                    tdo
);

   logic [RESULT_WIDTH-1:0] result_sr;

   // Zeros fill from the top so an over-long readback trails off with 0s.
   always_ff @(posedge tck or posedge test_logic_reset) begin
      if (test_logic_reset) begin
         result_sr <= '0;
      end else if (capture_load) begin
         result_sr <= load_value;
      end else if (shift_en) begin
         result_sr <= {1'b0, result_sr[RESULT_WIDTH-1:1]};
      end
   end

   assign tdo = result_sr[0];

endmodule

// File: rtl/tap_bridge.sv
// JTAG USER4 bridge: 8-bit inbound byte scans to a strobe, result readback on tdo.
// Optional TAP_BRIDGE_RX_LOCK_EN: once a result is locked, inbound scans are dropped.
module tap_bridge
   import tap_bridge_pkg::*;
#(
   parameter int RESULT_WIDTH = 32
) (
   input  logic                    tck,
   input  logic                    test_logic_reset,
   input  logic                    tdi,
   output logic                    tdo,
   input  logic                    ir_is_user,
   input  logic                    run_test_idle,
   input  logic                    capture_dr,
   input  logic                    shift_dr,
   input  logic                    update_dr,
   output logic                    rx_valid,
   output logic [BYTE_WIDTH-1:0]   rx_data,
   output logic [31:0]             rx_count,
   output logic [15:0]             rx_dropped,
   input  logic                    result_valid,
   input  logic [RESULT_WIDTH-1:0] result
);

   state_t                   state;
   logic [BIT_CNT_WIDTH-1:0] bit_cnt;
   logic [BYTE_WIDTH-1:0]    rx_sr;
   logic [RESULT_WIDTH-1:0]  res_q;
   logic                     res_locked;
   logic                     scan_ok;
   logic                     do_capture;
   logic                     do_shift;
   logic                     do_update;
   logic                     rx_block;
   logic                     byte_ok;

   // capture_dr wins over every other strobe, including an illegal update_dr.
   assign scan_ok    = ir_is_user & ~run_test_idle;
   assign do_capture = scan_ok & capture_dr;
   assign do_shift   = scan_ok & ~capture_dr & shift_dr & (state != IDLE);
   assign do_update  = scan_ok & ~capture_dr & ~shift_dr & update_dr & (state == SHIFTING);

`ifdef TAP_BRIDGE_RX_LOCK_EN
   assign rx_block = res_locked;
`else
   assign rx_block = 1'b0;
`endif

   assign byte_ok = (bit_cnt == BIT_CNT_WIDTH'(BYTE_WIDTH)) & ~rx_block;

   // Leaving USER4 or entering Run-Test/Idle silently discards a partial scan.
   always_ff @(posedge tck or posedge test_logic_reset) begin
      if (test_logic_reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         rx_sr      <= '0;
         rx_valid   <= 1'b0;
         rx_data    <= '0;
         rx_count   <= '0;
         rx_dropped <= '0;
      end else begin
         rx_valid <= 1'b0;
         if (!scan_ok) begin
            state <= IDLE;
         end else if (do_capture) begin
            state   <= CAPTURED;
            bit_cnt <= '0;
         end else if (do_shift) begin
            state <= SHIFTING;
            rx_sr <= {tdi, rx_sr[BYTE_WIDTH-1:1]};
            if (bit_cnt != '1) begin
               bit_cnt <= bit_cnt + BIT_CNT_WIDTH'(1);
            end
         end else if (do_update) begin
            state <= IDLE;
            if (byte_ok) begin
               rx_data  <= rx_sr;
               rx_valid <= 1'b1;
               rx_count <= rx_count + 32'd1;
            end else if (rx_dropped != '1) begin
               rx_dropped <= rx_dropped + 16'd1;
            end
         end
      end
   end

   // The first final result sticks; the host polls until it reads non-zero.
   always_ff @(posedge tck or posedge test_logic_reset) begin
      if (test_logic_reset) begin
         res_q      <= '0;
         res_locked <= 1'b0;
      end else if (result_valid && !res_locked) begin
         res_q      <= result;
         res_locked <= 1'b1;
      end
   end

   tap_result_shifter #(
      .RESULT_WIDTH(RESULT_WIDTH)
   ) u_result_shifter (
      .tck              (tck),
      .test_logic_reset (test_logic_reset),
      .capture_load     (do_capture),
      .shift_en         (do_shift),
      .load_value       (res_locked ? res_q : '0),
      .tdo              (tdo)
   );

endmodule

// File: tb/tb_tap_bridge.sv
// Self-checking bench for tap_bridge: scan-level reference model, per-cycle compare,
// directed host sequences and randomized scans.
module tb_tap_bridge;

`ifdef TAP_BRIDGE_RX_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic        tck = 1'b0;
   logic        test_logic_reset;
   logic        tdi;
   logic        tdo;
   logic        ir_is_user;
   logic        run_test_idle;
   logic        capture_dr;
   logic        shift_dr;
   logic        update_dr;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic [31:0] rx_count;
   logic [15:0] rx_dropped;
   logic        result_valid;
   logic [31:0] result;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state, kept per scan rather than per register.
   bit          m_locked   = 1'b0;
   logic [31:0] m_res      = '0;
   logic [31:0] exp_count  = '0;
   logic [15:0] exp_dropped = '0;
   bit          exp_valid  = 1'b0;
   logic [7:0]  exp_data   = '0;
   logic [31:0] exp_word   = '0;
   int          exp_idx    = 0;
   bit          check_en   = 1'b0;
   logic [7:0]  got_bytes[$];

   always #5 tck = ~tck;

   tap_bridge #(.RESULT_WIDTH(32)) dut (
      .tck              (tck),
      .test_logic_reset (test_logic_reset),
      .tdi              (tdi),
      .tdo              (tdo),
      .ir_is_user       (ir_is_user),
      .run_test_idle    (run_test_idle),
      .capture_dr       (capture_dr),
      .shift_dr         (shift_dr),
      .update_dr        (update_dr),
      .rx_valid         (rx_valid),
      .rx_data          (rx_data),
      .rx_count         (rx_count),
      .rx_dropped       (rx_dropped),
      .result_valid     (result_valid),
      .result           (result)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic exp_tdo();
      if (exp_idx < 32) return exp_word[exp_idx];
      return 1'b0;
   endfunction

   // Every cycle the outputs must agree with the model.
   always @(negedge tck) begin
      if (check_en) begin
         checkOutput("rx_valid", 32'(rx_valid), 32'(exp_valid));
         if (exp_valid) checkOutput("rx_data", 32'(rx_data), 32'(exp_data));
         checkOutput("rx_count", rx_count, exp_count);
         checkOutput("rx_dropped", 32'(rx_dropped), 32'(exp_dropped));
         checkOutput("tdo", 32'(tdo), 32'(exp_tdo()));
         if (rx_valid) got_bytes.push_back(rx_data);
      end
   end

   // Drive one cycle of TAP strobes; returns just after the sampling edge.
   task automatic applyStimulus(input logic cap, input logic sh, input logic upd,
                                input logic d, input logic user, input logic rti);
      bit          lock_now;
      logic [31:0] lock_val;
      capture_dr    = cap;
      shift_dr      = sh;
      update_dr     = upd;
      tdi           = d;
      ir_is_user    = user;
      run_test_idle = rti;
      lock_now      = result_valid && !m_locked;
      lock_val      = result;
      @(posedge tck);
      #1;
      exp_valid = 1'b0;
      if (lock_now) begin
         m_locked = 1'b1;
         m_res    = lock_val;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      test_logic_reset = 1'b1;
      m_locked    = 1'b0;
      m_res       = '0;
      exp_count   = '0;
      exp_dropped = '0;
      exp_valid   = 1'b0;
      exp_word    = '0;
      exp_idx     = 0;
      #1;
      checkOutput("reset_tdo", 32'(tdo), 32'd0);
      #1;
      test_logic_reset = 1'b0;
   endtask

   // end_mode: 0 update, 1 leave unfinished, 2 drop ir_is_user, 3 raise run_test_idle.
   task automatic scan(input int n, input logic [63:0] bits, input int end_mode,
                       input int abort_at, output logic [31:0] rb);
      logic [31:0] w;
      logic [7:0]  last;
      bit          aborted;
      bit          accept;
      logic        user;
      logic        rti;
      w       = m_locked ? m_res : 32'd0;
      aborted = 1'b0;
      last    = '0;
      rb      = '0;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      exp_word = w;
      exp_idx  = 0;
      @(negedge tck);
      rb[0] = tdo;
      for (int i = 0; i < n; i++) begin
         if (end_mode >= 2 && i >= abort_at) aborted = 1'b1;
         user = !(aborted && end_mode == 2);
         rti  = aborted && end_mode == 3;
         applyStimulus(1'b0, 1'b1, 1'b0, bits[i], user, rti);
         if (!aborted) begin
            exp_idx++;
            last = {bits[i], last[7:1]};
         end
         if (i + 1 < n && i + 1 < 32) begin
            @(negedge tck);
            rb[i+1] = tdo;
         end
      end
      if (end_mode != 1) begin
         if (end_mode >= 2) aborted = 1'b1;
         user   = !(aborted && end_mode == 2);
         rti    = aborted && end_mode == 3;
         accept = (n == 8) && !(LOCK_EN && m_locked);
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, user, rti);
         if (!aborted && n > 0) begin
            if (accept) begin
               exp_valid = 1'b1;
               exp_data  = last;
               exp_count = exp_count + 32'd1;
            end else if (exp_dropped != 16'hFFFF) begin
               exp_dropped = exp_dropped + 16'd1;
            end
         end
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] rb;
      logic [7:0]  msg [4];
      int          r;
      int          n;
      int          mode;
      msg[0] = 8'h31; msg[1] = 8'h2C; msg[2] = 8'h32; msg[3] = 8'h0A;

      test_logic_reset = 1'b1;
      tdi = 1'b0; ir_is_user = 1'b1; run_test_idle = 1'b0;
      capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
      result_valid = 1'b0; result = '0;
      #2;
      checkOutput("reset_tdo", 32'(tdo), 32'd0);
      checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
      checkOutput("reset_rx_data", 32'(rx_data), 32'd0);
      checkOutput("reset_rx_count", rx_count, 32'd0);
      checkOutput("reset_rx_dropped", 32'(rx_dropped), 32'd0);
      @(posedge tck);
      #1;
      test_logic_reset = 1'b0;
      check_en = 1'b1;

      $display("[TB] host sends \"1,2\\n\"");
      for (int i = 0; i < 4; i++) scan(8, 64'(msg[i]), 0, 0, rb);
      idle(2);
      checkOutput("msg_bytes", 32'(got_bytes.size()), 32'd4);
      for (int i = 0; i < 4 && i < got_bytes.size(); i++)
         checkOutput("msg_byte", 32'(got_bytes[i]), 32'(msg[i]));
      checkOutput("msg_count", rx_count, 32'd4);
      checkOutput("msg_dropped", 32'(rx_dropped), 32'd0);

      $display("[TB] readback before result is final");
      scan(32, 64'd0, 0, 0, rb);
      checkOutput("rb_not_ready", rb, 32'h0000_0000);
      checkOutput("rb_dropped", 32'(rx_dropped), 32'd1);
      checkOutput("rb_no_byte", 32'(got_bytes.size()), 32'd4);

      $display("[TB] lock result then change it");
      result = 32'h0000_1234;
      result_valid = 1'b1;
      idle(1);
      result = 32'hFFFF_FFFF;
      idle(2);
      scan(32, 64'd0, 0, 0, rb);
      checkOutput("rb_locked", rb, 32'h0000_1234);
      checkOutput("rb_dropped2", 32'(rx_dropped), 32'd2);
      result_valid = 1'b0;
      do_reset();

      $display("[TB] short scan, interrupted scan, then 0x41");
      scan(5, 64'h15, 0, 0, rb);
      checkOutput("short_dropped", 32'(rx_dropped), 32'd1);
      scan(3, 64'h5, 1, 0, rb);
      scan(8, 64'h41, 0, 0, rb);
      checkOutput("restart_bytes", 32'(got_bytes.size()), 32'd5);
      if (got_bytes.size() == 5) checkOutput("restart_byte", 32'(got_bytes[4]), 32'h41);
      checkOutput("restart_count", rx_count, 32'd1);

      $display("[TB] leave USER4 during 0x55 scan");
      scan(8, 64'h55, 2, 4, rb);
      checkOutput("ir_count", rx_count, 32'd1);
      checkOutput("ir_dropped", 32'(rx_dropped), 32'd1);

      $display("[TB] reset during readback");
      result = 32'h0003_0003;
      result_valid = 1'b1;
      idle(1);
      result_valid = 1'b0;
      scan(16, 64'd0, 1, 0, rb);
      checkOutput("mid_tdo_before", 32'(tdo), 32'd1);
      do_reset();
      checkOutput("mid_tdo", 32'(tdo), 32'd0);
      checkOutput("mid_count", rx_count, 32'd0);
      checkOutput("mid_dropped", 32'(rx_dropped), 32'd0);
      scan(32, 64'd0, 0, 0, rb);
      checkOutput("rb_after_reset", rb, 32'h0000_0000);

      $display("[TB] scan 0x31 with a locked result");
      result = 32'h0000_0042;
      result_valid = 1'b1;
      idle(1);
      result_valid = 1'b0;
      scan(8, 64'h31, 0, 0, rb);
      if (LOCK_EN) begin
         checkOutput("lock_dropped", 32'(rx_dropped), 32'd2);
         checkOutput("lock_count", rx_count, 32'd0);
      end else begin
         checkOutput("nolock_dropped", 32'(rx_dropped), 32'd1);
         checkOutput("nolock_count", rx_count, 32'd1);
      end

      $display("[TB] randomized scans");
      for (int it = 0; it < 200; it++) begin
         r = $urandom_range(0, 99);
         if (r < 4) begin
            result_valid = 1'b0;
            do_reset();
         end else if (r < 12) begin
            result = $urandom;
            result_valid = 1'b1;
            idle(1);
            result_valid = 1'($urandom_range(0, 1));
         end else begin
            n    = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 40) : 8;
            mode = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 3);
            scan(n, {$urandom, $urandom}, mode, $urandom_range(0, n), rb);
            idle($urandom_range(0, 2));
         end
      end
      result_valid = 1'b0;
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tap_bridge.md
# tap_bridge

JTAG user-register bridge that sits directly between the BSCAN primitive signals and the puzzle-solving core inside `user_logic`. On the inbound side it deserializes each 8-bit USER4 DR scan (LSB first) into a one-cycle byte strobe for the solver. On the outbound side it captures the solver's result into a shift register and presents it on `tdo`, LSB first, during readback scans. Everything runs in the `tck` domain.

## Interface
- `RESULT_WIDTH`, 32: width of the result readback register and of the readback scan.
- `tck`  in  1: JTAG clock; the only clock.
- `test_logic_reset`  in  1: asynchronous, active-high reset.
- `tdi`  in  1: serial data in, sampled on the `tck` rising edge while shifting.
- `tdo`  out  1: serial data out, `result_sr[0]`; reset 0.
- `ir_is_user`  in  1: the IR holds USER4; all DR strobes are ignored while low.
- `run_test_idle`, `capture_dr`, `shift_dr`, `update_dr`  in  1 each: TAP state decodes.
- `rx_valid`  out  1: one-cycle byte strobe; reset 0.
- `rx_data`  out  8: received byte, valid with `rx_valid`; reset 0x00.
- `rx_count`  out  32: bytes delivered, wraps at 2^32; reset 0.
- `rx_dropped`  out  16: scans rejected by the length check, saturates at 0xFFFF; reset 0.
- `result_valid`  in  1: the solver's result is final.
- `result`  in  RESULT_WIDTH: the solver's result.

## Operation
- The FSM is in `tap_bridge_pkg::state_t` and has three states:
  - IDLE --capture_dr--> CAPTURED: `bit_cnt` is cleared and `result_sr` is loaded.
  - CAPTURED --shift_dr--> SHIFTING.
  - SHIFTING --update_dr--> IDLE: the scan is evaluated.
  - EXIT/PAUSE cycles have all strobes low, and the FSM holds its state.
- `capture_dr` in any state restarts the scan: it returns the FSM to CAPTURED with `bit_cnt` = 0.
- `run_test_idle` high, or `ir_is_user` low, forces IDLE. Any partial scan is discarded without being counted as dropped.
- Inbound shift: each `shift_dr` cycle performs `rx_sr <= {tdi, rx_sr[7:1]}` and increments `bit_cnt`. `bit_cnt` is 6 bits and saturates at 63.
- Evaluation on `update_dr` in SHIFTING:
  - If `bit_cnt` == 8, `rx_data` is set to `rx_sr`, `rx_valid` pulses and `rx_count` increments.
  - Otherwise the scan is dropped and `rx_dropped` increments. A 32-bit readback scan with `tdi`=0 therefore never produces a byte.
- `update_dr` in IDLE or CAPTURED has no effect.
- Result latch: `res_q` copies `result` on the first cycle `result_valid` is high, and a `res_locked` flag then sets. Later changes to `result` are ignored until reset.
- Capture load: `result_sr` is loaded with `res_q` if `res_locked` is set, else with all zeros. Zero means "not ready" to the host, which polls until it reads a non-zero value.
- Outbound shift: each `shift_dr` cycle performs `result_sr <= {1'b0, result_sr[RESULT_WIDTH-1:1]}`. The inbound and outbound shifts occur in the same cycles.

## Timing
- All state updates happen on the `tck` rising edge. Strobes are sampled on the edge after the testbench or host drives them.
- `rx_valid` is registered. It is high for exactly the one cycle after the edge on which `update_dr` is sampled.
- `tdo` is combinational from the register. Bit k is stable from the edge completing capture (k=0), or from the k-th shift edge, until the next edge. The host samples it on the falling edge.
- Reset mid-scan clears all outputs, the FSM, `res_locked`, both shift registers and both counters immediately.
- A simultaneous `update_dr` and `capture_dr` is illegal per the TAP FSM. If it occurs, `capture_dr` wins.

## Configuration
- `TAP_BRIDGE_RX_LOCK_EN`:
  - Defined: once `res_locked` is set, inbound scans are still shifted but never produce `rx_valid`. Each such scan, including 8-bit scans, increments `rx_dropped`.
  - Undefined: the inbound path is independent of the result state.

## Structure
- `tap_bridge_pkg` holds:
  - `state_t` (IDLE, CAPTURED, SHIFTING);
  - `BYTE_WIDTH` = 8;
  - `BIT_CNT_WIDTH` = 6.
- One sub-module, `tap_result_shifter`, implements the RESULT_WIDTH capture/shift register and the `tdo` output. It has capture-load and shift-enable inputs.

## Test plan
- Reset, then scan the string "1,2\n" (4 × 8-bit scans) -> `rx_valid` pulses carrying 0x31, 0x2C, 0x32, 0x0A; `rx_count`=4; `rx_dropped`=0.
- Do a 32-bit readback with `result_valid`=0 -> `tdo` reads 0x00000000; `rx_dropped`=1; no `rx_valid`.
- Drive `result`=0x00001234 with `result_valid`=1, then change `result` to 0xFFFFFFFF; read back -> 0x00001234, LSB first on falling edges.
- Do a 5-bit scan, then `update_dr` -> no `rx_valid`, `rx_dropped` increments. Then do a 3-bit scan interrupted by `capture_dr` followed by a full 8-bit 0x41 scan -> a single `rx_data`=0x41.
- Clear `ir_is_user` during a scan of 0x55 -> no byte and no drop. Assert `test_logic_reset` mid-readback -> `tdo`=0, both counters 0, and a subsequent readback returns 0.
- With `TAP_BRIDGE_RX_LOCK_EN` defined, lock a result then scan 0x31 -> no `rx_valid`; `rx_dropped` increments.
